// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction-fetch / load-store memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes and memory strobes of the shared memory port, bundled as one interface.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
               mem_addr, mem_wdata, mem_rd_en, mem_wr_en, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
               mem_addr, mem_wdata, mem_rd_en, mem_wr_en, busy
    );

endinterface

// File: rtl/mem_lat_counter.sv
// Counts the cycles of one memory access; flags the first and the last (MEM_LAT-th) cycle.
module mem_lat_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic first_o,
    output logic last_o
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign first_o = (cnt_q == '0);
    assign last_o  = (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store: load/store priority with an
// anti-starvation streak limit, MEM_LAT-cycle access sequencing and one-cycle responses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int FAIR_MAX = 4
) (
    input  logic               ctrl_clk,
    input  logic               ctrl_rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int STRK_W = $clog2(FAIR_MAX + 1);
    localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(FAIR_MAX);

    state_e            state_q, state_d;
    logic [STRK_W-1:0] streak_q, streak_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              id_q, id_d;
    logic              mis_q, mis_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic arb, win_ls, win_if, ls_mis;
    logic lat_clr, lat_en, lat_first, lat_last;

    mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
        .clk     (ctrl_clk),
        .rst     (ctrl_rst),
        .clr_i   (lat_clr),
        .en_i    (lat_en),
        .first_o (lat_first),
        .last_o  (lat_last)
    );

    // Grants are masked during reset so every output reads 0 while it is held.
    assign arb    = !ctrl_rst && ((state_q == IDLE) || (state_q == RESP));
    assign ls_mis = is_misaligned(bus.ls_addr[1:0]);
    assign win_ls = bus.ls_req && !(bus.if_req && (streak_q == STRK_MAX));
    assign win_if = bus.if_req && !win_ls;

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        id_d       = id_q;
        mis_d      = mis_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        lat_clr    = 1'b0;
        lat_en     = 1'b0;

        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (win_ls) begin
                    // A misaligned access never reaches memory, so the memory-facing
                    // address/data latches keep their previous contents.
                    state_d = ls_mis ? RESP : ACCESS;
                    id_d    = REQ_LS;
                    we_d    = bus.ls_we;
                    mis_d   = ls_mis;
                    lat_clr = 1'b1;
                    if (!ls_mis) begin
                        addr_d  = bus.ls_addr;
                        wdata_d = bus.ls_wdata;
                    end
                    if (!bus.if_req) begin
                        streak_d = '0;
                    end else if (streak_q != STRK_MAX) begin
                        streak_d = streak_q + STRK_W'(1);
                    end
                end else if (win_if) begin
                    state_d  = ACCESS;
                    id_d     = REQ_IF;
                    we_d     = 1'b0;
                    mis_d    = 1'b0;
                    addr_d   = bus.if_addr;
                    lat_clr  = 1'b1;
                    streak_d = '0;
                end
            end
            ACCESS: begin
                lat_en = 1'b1;
                if (lat_last) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (id_q == REQ_LS) ls_rdata_d = bus.mem_rdata;
                        else                if_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ctrl_clk or posedge ctrl_rst) begin
        if (ctrl_rst) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            id_q       <= REQ_IF;
            mis_q      <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            id_q       <= id_d;
            mis_q      <= mis_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign bus.if_gnt    = arb && win_if;
    assign bus.ls_gnt    = arb && win_ls;
    assign bus.if_rvalid = (state_q == RESP) && (id_q == REQ_IF);
    assign bus.ls_rvalid = (state_q == RESP) && (id_q == REQ_LS);
    assign bus.ls_err    = bus.ls_rvalid && mis_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    // Strobes decode straight from state so an asynchronous reset drops them at once.
    assign bus.mem_rd_en = (state_q == ACCESS) && !we_q;
    assign bus.mem_wr_en = (state_q == ACCESS) && we_q && lat_first;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed scoreboard bench for mem_port_arbiter with a cycle-level reference model.
module tb_mem_port_arbiter;

    localparam int ML = 3;
    localparam int FM = 4;

    typedef struct packed {
        logic        we;
        logic        mis;
        logic [31:0] data;
    } ls_exp_t;

    logic clk = 1'b0;
    logic rst;
    logic init_mem;
    int   cyc;
    int   total;
    int   bad;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(ML), .FAIR_MAX(FM)
    ) dut (
        .ctrl_clk (clk),
        .ctrl_rst (rst),
        .bus      (bus.slave)
    );

    // Memory device and the bench's independent reference copy.
    logic [31:0] dev_mem [0:255];
    logic [31:0] ref_mem [0:255];

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h00A0_0093 : (32'h1000_0000 + 32'(i) * 32'h0001_0203);
    endfunction

    assign bus.mem_rdata = bus.mem_rd_en ? dev_mem[bus.mem_addr[9:2]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) dev_mem[i] <= init_word(i);
        end else if (bus.mem_wr_en) begin
            dev_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %b want %b", name, cyc, act, exp);
        end
    endtask

    // Scoreboard queues filled by the stimulus
    logic [31:0] if_q[$];
    ls_exp_t     ls_q[$];
    logic [31:0] if_last, ls_last;

    // Reference-model state: when the port is next free, streak, access window, due cycles
    int          next_arb, streak, win_lo, win_hi, if_due, ls_due, last_g, last_due;
    logic        win_we;
    logic [31:0] win_addr, win_wd;
    logic        log_en;
    logic        gnt_log[$];

    always @(negedge clk) begin
        logic exp_if, exp_ls, mis, exp_rd, exp_wr;
        int   lat;
        if (rst) begin
            next_arb = 0; streak = 0; win_lo = -1; win_hi = -2;
            if_due = -1; ls_due = -1; last_g = -1; last_due = -1;
            chk_b("rst_if_gnt", bus.if_gnt, 1'b0);
            chk_b("rst_ls_gnt", bus.ls_gnt, 1'b0);
            chk_b("rst_rd_en", bus.mem_rd_en, 1'b0);
            chk_b("rst_wr_en", bus.mem_wr_en, 1'b0);
            chk_b("rst_if_rvalid", bus.if_rvalid, 1'b0);
            chk_b("rst_ls_rvalid", bus.ls_rvalid, 1'b0);
            chk_b("rst_ls_err", bus.ls_err, 1'b0);
            chk_b("rst_busy", bus.busy, 1'b0);
            chk("rst_if_rdata", bus.if_rdata, 32'h0);
            chk("rst_ls_rdata", bus.ls_rdata, 32'h0);
            chk("rst_mem_addr", bus.mem_addr, 32'h0);
            chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        end else begin
            chk_b("busy", bus.busy, (cyc > last_g) && (cyc <= last_due));
            chk_b("if_rvalid", bus.if_rvalid, cyc == if_due);
            chk_b("ls_rvalid", bus.ls_rvalid, cyc == ls_due);
            if (!bus.ls_rvalid) chk_b("ls_err_idle", bus.ls_err, 1'b0);

            exp_rd = (cyc >= win_lo) && (cyc <= win_hi) && !win_we;
            exp_wr = (cyc == win_lo) && win_we;
            chk_b("mem_rd_en", bus.mem_rd_en, exp_rd);
            chk_b("mem_wr_en", bus.mem_wr_en, exp_wr);
            if (exp_rd || exp_wr) chk("mem_addr", bus.mem_addr, win_addr);
            if (exp_wr) chk("mem_wdata", bus.mem_wdata, win_wd);

            exp_if = 1'b0;
            exp_ls = 1'b0;
            if (cyc >= next_arb) begin
                if (bus.ls_req && !(bus.if_req && streak == FM)) exp_ls = 1'b1;
                else if (bus.if_req)                             exp_if = 1'b1;
            end
            chk_b("if_gnt", bus.if_gnt, exp_if);
            chk_b("ls_gnt", bus.ls_gnt, exp_ls);

            if (exp_ls) begin
                mis    = bus.ls_addr[1:0] != 2'b00;
                lat    = mis ? 1 : ML + 1;
                streak = bus.if_req ? ((streak < FM) ? streak + 1 : FM) : 0;
                if (!mis) begin
                    win_lo = cyc + 1; win_hi = cyc + ML;
                    win_we = bus.ls_we; win_addr = bus.ls_addr; win_wd = bus.ls_wdata;
                end
                ls_due = cyc + lat;
                last_g = cyc; last_due = cyc + lat; next_arb = cyc + lat;
                if (log_en) gnt_log.push_back(1'b1);
            end else if (exp_if) begin
                streak = 0;
                win_lo = cyc + 1; win_hi = cyc + ML;
                win_we = 1'b0; win_addr = bus.if_addr;
                if_due = cyc + ML + 1;
                last_g = cyc; last_due = cyc + ML + 1; next_arb = cyc + ML + 1;
                if (log_en) gnt_log.push_back(1'b0);
            end else if (cyc >= next_arb) begin
                next_arb = cyc + 1;
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a response pulse appears.
    always @(negedge clk) begin
        ls_exp_t e;
        logic [31:0] want;
        if (rst) begin
            if_q.delete();
            ls_q.delete();
            if_last = 32'h0;
            ls_last = 32'h0;
        end else begin
            if (bus.if_rvalid) begin
                if (if_q.size() == 0) begin
                    chk_b("if_resp_expected", 1'b0, 1'b1);
                end else begin
                    want = if_q.pop_front();
                    chk("if_rdata", bus.if_rdata, want);
                    if_last = want;
                end
            end
            if (bus.ls_rvalid) begin
                if (ls_q.size() == 0) begin
                    chk_b("ls_resp_expected", 1'b0, 1'b1);
                end else begin
                    e = ls_q.pop_front();
                    chk_b("ls_err", bus.ls_err, e.mis);
                    want = (!e.we && !e.mis) ? e.data : ls_last;
                    chk("ls_rdata", bus.ls_rdata, want);
                    ls_last = want;
                end
            end
        end
    end

    task automatic if_op(input logic [31:0] a);
        int n = 0;
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        if_q.push_back(ref_mem[a[9:2]]);
        do begin @(negedge clk); n++; end while (!bus.if_gnt && n < 200);
        chk_b("if_gnt_wait", bus.if_gnt, 1'b1);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
    endtask

    task automatic ls_op(input logic we, input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        ls_exp_t e;
        e.we   = we;
        e.mis  = a[1:0] != 2'b00;
        e.data = ref_mem[a[9:2]];
        if (we && !e.mis) ref_mem[a[9:2]] = wd;
        ls_q.push_back(e);
        bus.ls_req   = 1'b1;
        bus.ls_we    = we;
        bus.ls_addr  = a;
        bus.ls_wdata = wd;
        do begin @(negedge clk); n++; end while (!bus.ls_gnt && n < 200);
        chk_b("ls_gnt_wait", bus.ls_gnt, 1'b1);
        @(posedge clk); #1;
        bus.ls_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((if_q.size() != 0 || ls_q.size() != 0) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        repeat (ML + 2) begin @(posedge clk); #1; end
        chk("if_q_empty", 32'(if_q.size()), 32'h0);
        chk("ls_q_empty", 32'(ls_q.size()), 32'h0);
    endtask

    initial begin
        rst = 1'b1; init_mem = 1'b1; log_en = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; init_mem = 1'b0;
        @(posedge clk); #1;

        // Directed: fetch, store then load back, misaligned load and store
        if_op(32'h10);
        drain();
        ls_op(1'b1, 32'h40, 32'hDEAD_BEEF);
        ls_op(1'b0, 32'h40, 32'h0);
        ls_op(1'b0, 32'h42, 32'h0);
        ls_op(1'b1, 32'h43, 32'h1234_5678);
        ls_op(1'b0, 32'h40, 32'h0);
        drain();

        // Both requesters held continuously: four load/store wins, then a fetch
        log_en = 1'b1;
        fork
            for (int k = 0; k < 8; k++) ls_op(1'b0, 32'h200 + 32'(k) * 4, 32'h0);
            for (int k = 0; k < 2; k++) if_op(32'h80 + 32'(k) * 4);
        join
        drain();
        log_en = 1'b0;
        chk("fair_count", 32'(gnt_log.size()), 32'd10);
        for (int k = 0; k < 10 && k < gnt_log.size(); k++)
            chk_b("fair_order", gnt_log[k], (k % 5) != 4);

        // Randomized mixed traffic
        fork
            for (int k = 0; k < 40; k++) begin
                logic [31:0] a;
                a = 32'h200 + 32'($urandom_range(0, 127)) * 4;
                if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
                ls_op(1'($urandom_range(0, 1)), a, $urandom);
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            for (int k = 0; k < 40; k++) begin
                if_op(32'($urandom_range(0, 127)) * 4 + 32'($urandom_range(0, 3)));
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
        join
        drain();

        // Asynchronous reset in the second ACCESS cycle of a read
        ls_op(1'b0, 32'h208, 32'h0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_b("arst_rd_en", bus.mem_rd_en, 1'b0);
        chk_b("arst_busy", bus.busy, 1'b0);
        chk_b("arst_ls_rvalid", bus.ls_rvalid, 1'b0);
        chk("arst_ls_rdata", bus.ls_rdata, 32'h0);
        chk("arst_mem_addr", bus.mem_addr, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        ls_op(1'b0, 32'h40, 32'h0);
        if_op(32'h10);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory port between instruction fetch and load/store traffic issued by the control unit. Each requester gets a request/grant handshake and a one-cycle response pulse; the block sequences the memory strobes over a configurable number of access cycles. Load/store has priority, and a streak counter prevents fetch starvation. It sits between the control unit / PC / MAR-MDR datapath and the memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory access cycles per transfer (≥1)
- FAIR_MAX, 4, consecutive load/store wins over a waiting fetch before fetch is forced (≥1)

- ctrl_clk  in  1  single clock, rising edge
- ctrl_rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle fetch data valid
- if_rdata  out  DATA_W  fetch data, held until next fetch response
- ls_req, ls_we  in  1  data request; we=1 store, 0 load
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  data request accepted this cycle
- ls_rvalid  out  1  one-cycle completion (load data or store ack)
- ls_rdata  out  DATA_W  load data, held until next load response
- ls_err  out  1  qualifies ls_rvalid: misaligned access, no memory cycle
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rd_en, mem_wr_en  out  1  memory strobes
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- Arbitration occurs in IDLE and RESP. Winner: ls if ls_req, unless streak == FAIR_MAX and if_req → if. Otherwise if, if if_req.
- Grant is combinational in the arbitration cycle. At that edge: latch addr, wdata, we, and requester id; clear the latency counter; go to ACCESS.
- No request at arbitration → go to IDLE.
- Streak update at each grant:
  - ls granted while if_req=1 → +1, saturating at FAIR_MAX.
  - if granted, or ls granted with if_req=0 → 0.
- ACCESS:
  - mem_addr/mem_wdata driven from latches.
  - Read: mem_rd_en=1 for all MEM_LAT cycles. mem_rdata is captured on the last one.
  - Write: mem_wr_en=1 only on the first ACCESS cycle.
  - After MEM_LAT cycles → RESP.
- RESP: rvalid=1 to the latched requester for exactly one cycle. Arbitration happens in the same cycle, allowing back-to-back grants.
- Misaligned ls (ls_addr[1:0]≠0):
  - Granted normally.
  - ACCESS is skipped: no strobes, and ls_rdata is unchanged.
  - Next cycle is RESP with ls_rvalid=1 and ls_err=1.
- ls_err is 0 whenever ls_rvalid=0.
- Fetch addresses are not alignment-checked.
- if_gnt and ls_gnt are never both 1.
- A request still high on the cycle after its grant is a new request.

## Timing
- Reset values: state IDLE, streak 0. All outputs 0, including rdata, mem_addr and mem_wdata.
- Reset is asynchronous. Mid-ACCESS it drops strobes immediately, the aborted transfer gets no rvalid, and held rdata clears.
- Aligned request at cycle 0 from IDLE:
  - gnt at cycle 0.
  - Strobes during cycles 1..MEM_LAT.
  - rvalid at cycle MEM_LAT+1.
- Misaligned ls: gnt at cycle 0, ls_rvalid+ls_err at cycle 1.
- Sustained throughput: one transfer per MEM_LAT+1 cycles.
- Outside ACCESS: strobes 0; mem_addr/mem_wdata hold their last values.
- Latency counter width: clog2(MEM_LAT+1). Streak counter width: clog2(FAIR_MAX+1).

## Structure
- Shared package mem_arb_pkg:
  - state enum (IDLE/ACCESS/RESP)
  - requester id constants (REQ_IF=0, REQ_LS=1)
  - alignment mask constant
- One sub-module, mem_lat_counter: load/clear and terminal-count flag for MEM_LAT. Arbitration and FSM stay in the top.

## Test plan
- MEM_LAT=1. if_req with if_addr=0x10, memory returns 0x00A00093 → if_gnt at c0, mem_rd_en at c1, if_rvalid with if_rdata=0x00A00093 at c2.
- MEM_LAT=3. Store ls_addr=0x40, ls_wdata=0xDEADBEEF → mem_wr_en exactly one cycle (c1), ls_rvalid at c4, ls_err=0. A following load of 0x40 returns 0xDEADBEEF.
- if_req and ls_req both held continuously, FAIR_MAX=4 → grant order ls,ls,ls,ls,if, repeating. No cycle has both gnts.
- Load ls_addr=0x42 → ls_gnt c0, no mem strobes, ls_rvalid=ls_err=1 at c1, ls_rdata unchanged.
- MEM_LAT=3. Assert ctrl_rst asynchronously during the 2nd ACCESS cycle of a read → strobes drop the same cycle, no rvalid, all outputs 0, busy=0. After release, a new request is granted normally.
